// File: rtl/seq_alu_if.sv
// Start/done handshake and operand/result bus between the control unit and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic               start;
  logic [OPW-1:0]     opcode;
  logic [WIDTH-1:0]   input_a;
  logic [WIDTH-1:0]   input_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, opcode, input_a, input_b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, opcode, input_a, input_b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift ops, radix-2 Booth signed multiply,
// restoring signed divide on magnitudes with a final sign-fix cycle.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int OPW   = 5
) (
  input logic       clk,
  input logic       clr,
  seq_alu_if.slave  bus
);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(7);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(9);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(10);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(11);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(12);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH:0]     acc_q, acc_d;   // Booth partial product / division remainder
  logic [WIDTH-1:0]   qr_q, qr_d;     // multiplier / quotient shift register
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;       // multiplicand / divisor magnitude
  logic               negq_q, negq_d, negr_q, negr_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept;
  logic [WIDTH:0]     m_ext, b_sum, rem_sh, trial;
  logic [WIDTH:0]     b_acc;
  logic [WIDTH-1:0]   b_qr;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] dbl, ror_t, rol_t;
  logic [WIDTH-1:0]   alu_lo, alu_hi, fix_lo, fix_hi, abs_a, abs_b;
  logic               alu_dbz;

  assign accept = bus.start && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        if (bus.opcode == OP_MUL)                          state_d = S_MUL;
        else if (bus.opcode == OP_DIV && bus.input_b != '0) state_d = S_DIV;
        else                                                state_d = S_EXEC;
      end
      S_EXEC: state_d = S_IDLE;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_IDLE;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ops, including the divide-by-zero shortcut
  always_comb begin
    amt     = b_q[SHW-1:0];
    dbl     = {a_q, a_q};
    ror_t   = dbl >> amt;
    rol_t   = dbl << amt;
    alu_lo  = '0;
    alu_hi  = '0;
    alu_dbz = 1'b0;
    case (op_q)
      OP_ADD:  alu_lo = a_q + b_q;
      OP_SUB:  alu_lo = a_q - b_q;
      OP_AND:  alu_lo = a_q & b_q;
      OP_OR:   alu_lo = a_q | b_q;
      OP_SHR:  alu_lo = a_q >> amt;
      OP_SHRA: alu_lo = $unsigned($signed(a_q) >>> amt);
      OP_SHL:  alu_lo = a_q << amt;
      OP_ROR:  alu_lo = ror_t[WIDTH-1:0];
      OP_ROL:  alu_lo = rol_t[2*WIDTH-1:WIDTH];
      OP_NEG:  alu_lo = '0 - a_q;
      OP_NOT:  alu_lo = ~a_q;
      OP_DIV: begin
        alu_lo  = '1;
        alu_hi  = a_q;
        alu_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // Iteration datapath: one Booth step and one restoring-division step
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    unique case ({qr_q[0], qm1_q})
      2'b01:   b_sum = acc_q + m_ext;
      2'b10:   b_sum = acc_q - m_ext;
      default: b_sum = acc_q;
    endcase
    b_acc  = {b_sum[WIDTH], b_sum[WIDTH:1]};
    b_qr   = {b_sum[0], qr_q[WIDTH-1:1]};
    rem_sh = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, m_q};
    fix_lo = negq_q ? ('0 - qr_q) : qr_q;
    fix_hi = negr_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    abs_a  = bus.input_a[WIDTH-1] ? ('0 - bus.input_a) : bus.input_a;
    abs_b  = bus.input_b[WIDTH-1] ? ('0 - bus.input_b) : bus.input_b;
  end

  always_comb begin
    busy_d   = (state_q != S_IDLE) && (state_d != S_IDLE);
    done_d   = (state_q != S_IDLE) && (state_d == S_IDLE);
    result_d = result_q;
    dbz_d    = dbz_q;
    cnt_d    = (state_q == S_MUL || state_q == S_DIV) ? cnt_q + 1'b1 : '0;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    if (done_d) begin
      dbz_d = 1'b0;
      case (state_q)
        S_EXEC: begin
          result_d = {alu_hi, alu_lo};
          dbz_d    = alu_dbz;
        end
        S_MUL:   result_d = {b_acc[WIDTH-1:0], b_qr};
        S_FIX:   result_d = {fix_hi, fix_lo};
        default: ;
      endcase
    end
    if (accept) begin
      op_d   = bus.opcode;
      a_d    = bus.input_a;
      b_d    = bus.input_b;
      acc_d  = '0;
      qm1_d  = 1'b0;
      negq_d = bus.input_a[WIDTH-1] ^ bus.input_b[WIDTH-1];
      negr_d = bus.input_a[WIDTH-1];
      if (bus.opcode == OP_MUL) begin
        qr_d = bus.input_b;
        m_d  = bus.input_a;
      end else begin
        qr_d = abs_a;
        m_d  = abs_b;
      end
    end else if (state_q == S_MUL) begin
      acc_d = b_acc;
      qr_d  = b_qr;
      qm1_d = qr_q[0];
    end else if (state_q == S_DIV) begin
      if (!trial[WIDTH]) begin
        acc_d = trial;
        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh;
        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: transaction-level model checked every cycle,
// plus hand-computed literal results and latencies per operation.
module tb_seq_alu;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  seq_alu_if #(.WIDTH(32), .OPW(5)) bus();
  seq_alu #(.WIDTH(32), .SHW(5), .OPW(5)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  // model state
  bit          m_act, m_busy, m_done, m_dbz, p_dz;
  logic [63:0] m_res, p_res;
  int          m_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation semantics from plain integer arithmetic
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r, output bit dz, output int lat);
    logic [31:0] lo, hi;
    logic [4:0]  sh;
    longint      sa, sb, q, rm;
    logic [63:0] p;
    sh = b[4:0]; lo = '0; hi = '0; dz = 1'b0; lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0:  lo = a + b;
      5'd1:  lo = a - b;
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4:  lo = a >> sh;
      5'd5:  lo = $unsigned($signed(a) >>> sh);
      5'd6:  lo = a << sh;
      5'd7:  lo = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      5'd8:  lo = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      5'd9:  begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; lat = 32; end
      5'd10: if (b == 0) begin
               lo = '1; hi = a; dz = 1'b1;
             end else begin
               q = sa / sb; rm = sa % sb;
               lo = q[31:0]; hi = rm[31:0]; lat = 33;
             end
      5'd11: lo = 32'd0 - a;
      5'd12: lo = ~a;
      default: ;
    endcase
    r = {hi, lo};
  endfunction

  initial begin
    bit idle;
    m_act = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_res = '0; m_left = 0;
    forever begin
      @(posedge clk);
      if (clr) begin
        m_act = 0; m_busy = 0; m_done = 0; m_res = '0; m_dbz = 0;
      end else begin
        idle = !m_act;
        m_done = 0;
        if (m_act) begin
          m_left--;
          if (m_left == 0) begin
            m_act = 0; m_busy = 0; m_done = 1; m_res = p_res; m_dbz = p_dz;
          end else m_busy = 1;
        end
        if (idle && bus.start) begin
          model(bus.opcode, bus.input_a, bus.input_b, p_res, p_dz, m_left);
          m_act = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 64'(bus.busy), 64'(m_busy));
        check("done", 64'(bus.done), 64'(m_done));
        check("result", bus.result, m_res);
        check("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
      end
    end
  end

  // Issue at the current negedge, wait for done; inj>0 pulses an ignored DIV start.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input bit exp_dz,
                        input int exp_lat, input int inj);
    int k, nb;
    bit seen;
    bus.start = 1'b1; bus.opcode = op; bus.input_a = a; bus.input_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.opcode = 5'($urandom); bus.input_a = $urandom; bus.input_b = $urandom;
    k = 0; nb = 0; seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.busy) nb++;
      if (bus.done) seen = 1;
      bus.start = 1'b0;
      if (k == inj) begin
        bus.start = 1'b1; bus.opcode = 5'd10; bus.input_a = 32'd100; bus.input_b = 32'd7;
      end
    end
    check({name, " latency"}, 64'(k), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(nb), 64'((exp_lat > 1) ? exp_lat - 1 : 0));
    check({name, " result"}, bus.result, exp_res);
    check({name, " dbz"}, 64'(bus.div_by_zero), 64'(exp_dz));
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0; bus.opcode = '0; bus.input_a = '0; bus.input_b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", bus.result, 64'd0);
    check("reset dbz", 64'(bus.div_by_zero), 64'd0);
    clr = 1'b0;
    @(negedge clk);

    run_op("ADD", 5'd0, 32'd2, 32'd3, 64'h0000_0000_0000_0005, 0, 1, 0);
    run_op("SUB", 5'd1, 32'd12, 32'd17, 64'h0000_0000_FFFF_FFFB, 0, 1, 0);
    run_op("MUL -3*7", 5'd9, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 32, 0);
    run_op("MUL minneg^2", 5'd9, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 32, 0);
    run_op("MUL -1*-1", 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 32, 0);
    run_op("DIV -17/5", 5'd10, -32'sd17, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD, 0, 33, 0);
    run_op("DIV 7/-2", 5'd10, 32'd7, -32'sd2, 64'h0000_0001_FFFF_FFFD, 0, 33, 0);
    run_op("DIV minneg/-1", 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 33, 0);
    run_op("DIV by 0", 5'd10, 32'd17, 32'd0, 64'h0000_0011_FFFF_FFFF, 1, 1, 0);
    run_op("ADD clears dbz", 5'd0, 32'd1, 32'd1, 64'h0000_0000_0000_0002, 0, 1, 0);
    run_op("ROR", 5'd7, 32'd1, 32'd1, 64'h0000_0000_8000_0000, 0, 1, 0);
    run_op("SHRA", 5'd5, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000, 0, 1, 0);
    run_op("SHL mod 32", 5'd6, 32'd1, 32'd37, 64'h0000_0000_0000_0020, 0, 1, 0);
    run_op("SHL by 0", 5'd6, 32'h0000_00A5, 32'd0, 64'h0000_0000_0000_00A5, 0, 1, 0);
    run_op("ROL", 5'd8, 32'h8000_0001, 32'd4, 64'h0000_0000_0000_0018, 0, 1, 0);
    run_op("SHR", 5'd4, 32'hF000_0000, 32'd8, 64'h0000_0000_00F0_0000, 0, 1, 0);
    run_op("AND", 5'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'h0000_0000_0F00_0F00, 0, 1, 0);
    run_op("OR", 5'd3, 32'hFF00_0000, 32'h0000_00FF, 64'h0000_0000_FF00_00FF, 0, 1, 0);
    run_op("NEG", 5'd11, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFB, 0, 1, 0);
    run_op("NOT", 5'd12, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFFF, 0, 1, 0);
    run_op("illegal op", 5'd13, 32'd9, 32'd9, 64'h0000_0000_0000_0000, 0, 1, 0);
    run_op("MUL w/ ignored start", 5'd9, 32'd1000, -32'sd3, 64'hFFFF_FFFF_FFFF_F448, 0, 32, 10);

    // clr mid-MUL aborts with no done pulse
    bus.start = 1'b1; bus.opcode = 5'd9; bus.input_a = 32'd5; bus.input_b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr busy", 64'(bus.busy), 64'd0);
    check("clr done", 64'(bus.done), 64'd0);
    check("clr result", bus.result, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no done after clr", 64'(ndone), 64'd0);
    run_op("ADD after clr", 5'd0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_0000_0000, 0, 1, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
